board_commit_ctrl: RTL and testbench

- Owns the 8x8 board-state register array that drives the VGA pixel generator's board input.
- Accepts move requests from game logic through a valid/ready queue.
- Applies queued moves and re-initialisation only when vertical sync begins, so the displayed board never changes mid-frame.
- Sits between the move/rules logic and the VGA top level; the VGA pixel generator is its only reader.

---
 rtl/board_pkg.sv | 61 ++++++
 rtl/move_fifo.sv | 55 +++++
 rtl/board_commit_ctrl.sv | 159 +++++++++++++++
 tb/tb_board_commit_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared types and constants for the chess board commit controller.
// Piece code is {type[2:0], color[1:0]}; squares are {row[2:0], col[2:0]}.
package board_pkg;

  typedef logic [4:0] piece_t;
  typedef logic [5:0] square_t;
  typedef piece_t [7:0] row_t;

  localparam logic [2:0] TYPE_EMPTY  = 3'd0;
  localparam logic [2:0] TYPE_PAWN   = 3'd1;
  localparam logic [2:0] TYPE_KNIGHT = 3'd2;
  localparam logic [2:0] TYPE_BISHOP = 3'd3;
  localparam logic [2:0] TYPE_ROOK   = 3'd4;
  localparam logic [2:0] TYPE_QUEEN  = 3'd5;
  localparam logic [2:0] TYPE_KING   = 3'd6;

  localparam logic [1:0] COLOR_NONE  = 2'b00;
  localparam logic [1:0] COLOR_WHITE = 2'b01;
  localparam logic [1:0] COLOR_BLACK = 2'b10;

  localparam piece_t EMPTY = {TYPE_EMPTY, COLOR_NONE};

  typedef struct packed {
    square_t src;
    square_t dst;
    piece_t  promote;
  } move_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_MOVE_DST,
    ST_MOVE_SRC
  } state_t;

  // Standard start position for one row; black occupies rows 0-1, white rows 6-7.
  function automatic row_t START_ROW(input logic [2:0] row);
    row_t       r;
    logic [1:0] c;
    r = {8{EMPTY}};
    c = (row < 3'd4) ? COLOR_BLACK : COLOR_WHITE;
    case (row)
      3'd0, 3'd7: begin
        r[0] = {TYPE_ROOK,   c};
        r[1] = {TYPE_KNIGHT, c};
        r[2] = {TYPE_BISHOP, c};
        r[3] = {TYPE_QUEEN,  c};
        r[4] = {TYPE_KING,   c};
        r[5] = {TYPE_BISHOP, c};
        r[6] = {TYPE_KNIGHT, c};
        r[7] = {TYPE_ROOK,   c};
      end
      3'd1, 3'd6: begin
        for (int i = 0; i < 8; i++) r[i] = {TYPE_PAWN, c};
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/move_fifo.sv
// Small power-of-two FIFO holding pending moves; flush discards all entries.
module move_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 17,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && (r_count != CNT_W'(DEPTH));
  assign w_pop   = i_pop && (r_count != '0);
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/board_commit_ctrl.sv
// Owns the 8x8 board array read by the VGA pixel generator; queued moves and
// re-initialisation are applied only at the start of vertical sync.
module board_commit_ctrl
  import board_pkg::*;
#(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned MAX_PER_FRAME = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       move_valid,
  output logic       move_ready,
  input  logic [5:0] move_src,
  input  logic [5:0] move_dst,
  input  logic [4:0] move_promote,
  input  logic       init_req,
  output logic [4:0] boardPos [8][8],
  output logic       busy,
  output logic       commit_pulse
);

  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned DONE_W = $clog2(MAX_PER_FRAME + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_vsync_q;
  logic              r_init_pend;
  logic [2:0]        r_row_cnt;
  logic [DONE_W-1:0] r_n_done;

  logic              w_vs_edge;
  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  move_t             w_wdata;
  move_t             w_head;
  piece_t            w_dst_piece;
  row_t              w_start [8];

  logic              w_enter_init;
  logic              w_enter_move;
  logic              w_init_row;
  logic              w_wr_dst;
  logic              w_wr_src;
  logic              w_more_ok;

  assign w_vs_edge    = r_vsync_q & ~vsync;
  assign move_ready   = !w_full && (r_state != ST_INIT);
  assign w_push       = move_valid && move_ready;
  assign w_wdata      = '{src: move_src, dst: move_dst, promote: move_promote};
  assign busy         = (r_state != ST_IDLE);
  assign commit_pulse = w_wr_src;
  assign w_more_ok    = (w_count > CNT_W'(1)) &&
                        ((32'(r_n_done) + 32'd1) < 32'(MAX_PER_FRAME));
  assign w_dst_piece  = (w_head.promote != EMPTY) ? w_head.promote
                                                  : boardPos[w_head.src[5:3]][w_head.src[2:0]];

  always_comb begin
    for (int r = 0; r < 8; r++) w_start[r] = START_ROW(3'(r));
  end

  move_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(move_t))
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Next-state and per-state actions.
  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_flush      = 1'b0;
    w_enter_init = 1'b0;
    w_enter_move = 1'b0;
    w_init_row   = 1'b0;
    w_wr_dst     = 1'b0;
    w_wr_src     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_vs_edge) begin
          if (r_init_pend) begin
            w_state_nxt  = ST_INIT;
            w_flush      = 1'b1;
            w_enter_init = 1'b1;
          end else if (!w_empty) begin
            w_state_nxt  = ST_MOVE_DST;
            w_enter_move = 1'b1;
          end
        end
      end
      ST_INIT: begin
        w_init_row = 1'b1;
        if (r_row_cnt == 3'd7) w_state_nxt = ST_IDLE;
      end
      ST_MOVE_DST: begin
        w_wr_dst    = (w_head.src != w_head.dst);
        w_state_nxt = ST_MOVE_SRC;
      end
      ST_MOVE_SRC: begin
        w_pop       = 1'b1;
        w_wr_src    = (w_head.src != w_head.dst);
        w_state_nxt = w_more_ok ? ST_MOVE_DST : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_vsync_q   <= 1'b1;
      r_init_pend <= 1'b0;
      r_row_cnt   <= 3'd0;
      r_n_done    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_vsync_q <= vsync;
      // A request arriving on the INIT entry cycle stays pending for the next frame.
      if (w_enter_init) r_init_pend <= 1'b0;
      if (init_req)     r_init_pend <= 1'b1;
      if (w_enter_init)    r_row_cnt <= 3'd0;
      else if (w_init_row) r_row_cnt <= r_row_cnt + 3'd1;
      if (w_enter_move) r_n_done <= '0;
      else if (w_pop)   r_n_done <= r_n_done + DONE_W'(1);
    end
  end

  // Board array: the only storage the pixel generator ever sees.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          boardPos[3'(r)][3'(c)] <= w_start[3'(r)][3'(c)];
    end else begin
      if (w_init_row) begin
        for (int c = 0; c < 8; c++)
          boardPos[r_row_cnt][3'(c)] <= w_start[r_row_cnt][3'(c)];
      end
      if (w_wr_dst) boardPos[w_head.dst[5:3]][w_head.dst[2:0]] <= w_dst_piece;
      if (w_wr_src) boardPos[w_head.src[5:3]][w_head.src[2:0]] <= EMPTY;
    end
  end

endmodule

// File: tb/tb_board_commit_ctrl.sv
// Bench for board_commit_ctrl: directed frame-timing scenarios followed by
// random move/init traffic checked against a frame-level board model.
module tb_board_commit_ctrl;

  localparam int DEPTH = 4;
  localparam int MAXF  = 4;

  logic       clk = 1'b0;
  logic       reset, vsync, mv1, mv2, init_req;
  logic [5:0] src, dst;
  logic [4:0] pro;
  logic       rdy1, rdy2, busy1, busy2, cp1, cp2;
  logic [4:0] bp1 [8][8];
  logic [4:0] bp2 [8][8];

  always #5 clk = ~clk;

  board_commit_ctrl #(.DEPTH(DEPTH), .MAX_PER_FRAME(MAXF)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .move_valid(mv1), .move_ready(rdy1),
    .move_src(src), .move_dst(dst), .move_promote(pro), .init_req(init_req),
    .boardPos(bp1), .busy(busy1), .commit_pulse(cp1));

  board_commit_ctrl #(.DEPTH(DEPTH), .MAX_PER_FRAME(2)) dut2 (
    .clk(clk), .reset(reset), .vsync(vsync), .move_valid(mv2), .move_ready(rdy2),
    .move_src(src), .move_dst(dst), .move_promote(pro), .init_req(init_req),
    .boardPos(bp2), .busy(busy2), .commit_pulse(cp2));

  typedef struct { logic [5:0] s; logic [5:0] d; logic [4:0] p; } mv_t;

  mv_t        mq[$];
  logic [4:0] mb [8][8];
  bit         m_init_pend;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         g_p2, g_b2;

  function automatic logic [5:0] sq(input int r, input int c);
    return {r[2:0], c[2:0]};
  endfunction

  // Start position from the chess rules: back rank R N B Q K B N R, pawns in front.
  function automatic logic [4:0] start_piece(input int r, input int c);
    int back[8] = '{4, 2, 3, 5, 6, 3, 2, 4};
    case (r)
      0: return {3'(back[c]), 2'b10};
      1: return {3'd1, 2'b10};
      6: return {3'd1, 2'b01};
      7: return {3'(back[c]), 2'b01};
      default: return 5'd0;
    endcase
  endfunction

  task automatic model_start();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mb[r][c] = start_piece(r, c);
  endtask

  task automatic model_reset();
    model_start();
    mq.delete();
    m_init_pend = 0;
  endtask

  // One vsync edge worth of work: either a full re-init or up to MAXF moves.
  task automatic model_frame(output int e_busy, output int e_pulse, output int e_nrdy);
    mv_t m;
    int  n;
    e_pulse = 0;
    e_nrdy  = 0;
    if (m_init_pend) begin
      model_start();
      mq.delete();
      m_init_pend = 0;
      e_busy = 8;
      e_nrdy = 8;
    end else begin
      n = (mq.size() < MAXF) ? mq.size() : MAXF;
      e_busy = 2 * n;
      if (mq.size() >= DEPTH) e_nrdy = 2;
      for (int i = 0; i < n; i++) begin
        m = mq.pop_front();
        if (m.s != m.d) begin
          e_pulse++;
          mb[m.d[5:3]][m.d[2:0]] = (m.p != 5'd0) ? m.p : mb[m.s[5:3]][m.s[2:0]];
          mb[m.s[5:3]][m.s[2:0]] = 5'd0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_board(input string tag);
    int bad = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (bp1[r][c] !== mb[r][c]) begin
          if (bad == 0) $display("  first bad square [%0d][%0d] dut=%b model=%b", r, c, bp1[r][c], mb[r][c]);
          bad++;
        end
    chk(tag, bad, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [5:0] s, input logic [5:0] d, input logic [4:0] p);
    mv_t m;
    bit  exp_acc;
    exp_acc = (mq.size() < DEPTH);
    src = s; dst = d; pro = p;
    chk("ready_before_push", rdy1, exp_acc);
    mv1 = 1'b1;
    tick();
    mv1 = 1'b0;
    if (exp_acc) begin
      m.s = s; m.d = d; m.p = p;
      mq.push_back(m);
    end
  endtask

  task automatic frame(input string tag);
    int eb, ep, en, gb, gp, gn;
    model_frame(eb, ep, en);
    gb = 0; gp = 0; gn = 0; g_p2 = 0; g_b2 = 0;
    vsync = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (i == 3) vsync = 1'b1;
      gb += int'(busy1); gp += int'(cp1); gn += int'(!rdy1);
      g_p2 += int'(cp2); g_b2 += int'(busy2);
    end
    chk({tag, "_busy_cycles"}, gb, eb);
    chk({tag, "_commit_pulses"}, gp, ep);
    chk({tag, "_notready_cycles"}, gn, en);
    chk({tag, "_idle_after"}, busy1, 0);
    chk({tag, "_ready_after"}, rdy1, mq.size() < DEPTH);
    chk_board({tag, "_board"});
  endtask

  initial begin
    int  eb, ep, en, gb, gp, acc, k;
    bit  take;
    logic [5:0] rs, rd;
    logic [4:0] rp;

    reset = 1'b1; vsync = 1'b1; mv1 = 1'b0; mv2 = 1'b0; init_req = 1'b0;
    src = '0; dst = '0; pro = '0;
    repeat (3) tick();
    reset = 1'b0;
    model_reset();

    // Reset state
    chk("rst_black_king", bp1[0][4], 5'b11010);
    chk("rst_white_queen", bp1[7][3], 5'b10101);
    chk("rst_empty_44", bp1[4][4], 5'd0);
    chk("rst_ready", rdy1, 1);
    chk("rst_busy", busy1, 0);
    chk("rst_commit", cp1, 0);
    chk_board("rst_board");

    // Single move: nothing happens until vsync falls, then dst at n+1, src at n+2
    push_one(sq(6, 4), sq(4, 4), 5'd0);
    repeat (3) tick();
    chk("t2_no_edge_hold", bp1[4][4], 5'd0);
    model_frame(eb, ep, en);
    vsync = 1'b0;
    chk("t2_busy_n", busy1, 0);
    tick();
    chk("t2_busy_n1", busy1, 1);
    chk("t2_dst_n1", bp1[4][4], 5'd0);
    chk("t2_pulse_n1", cp1, 0);
    tick();
    chk("t2_dst_n2", bp1[4][4], 5'b00101);
    chk("t2_src_n2", bp1[6][4], 5'b00101);
    chk("t2_pulse_n2", cp1, 1);
    tick();
    chk("t2_src_n3", bp1[6][4], 5'd0);
    chk("t2_pulse_n3", cp1, 0);
    chk("t2_busy_n3", busy1, 0);
    vsync = 1'b1;
    repeat (3) tick();
    chk_board("t2_board");

    // Fill the queue; a fifth request is held and accepted once space opens
    push_one(sq(6, 0), sq(5, 0), 5'd0);
    push_one(sq(6, 1), sq(5, 1), 5'd0);
    push_one(sq(6, 2), sq(4, 2), 5'd0);
    push_one(sq(0, 1), sq(2, 2), 5'd0);
    chk("t3_full_ready", rdy1, 0);
    src = sq(7, 6); dst = sq(5, 5); pro = 5'd0; mv1 = 1'b1;
    repeat (2) begin
      tick();
      chk("t3_held_ready", rdy1, 0);
    end
    model_frame(eb, ep, en);
    vsync = 1'b0; gb = 0; gp = 0; acc = 0;
    for (int i = 0; i < 24; i++) begin
      take = mv1 && rdy1;
      tick();
      if (take) begin mv1 = 1'b0; acc++; end
      if (i == 3) vsync = 1'b1;
      gb += int'(busy1); gp += int'(cp1);
    end
    chk("t3_busy_cycles", gb, eb);
    chk("t3_commit_pulses", gp, ep);
    chk("t3_fifth_accepted", acc, 1);
    mq.push_back('{s: sq(7, 6), d: sq(5, 5), p: 5'd0});
    chk_board("t3_board");
    frame("t3_fifth_frame");

    // Promotion and a src==dst entry
    push_one(sq(1, 0), sq(7, 0), 5'b10101);
    frame("t5_promote");
    chk("t5_promoted", bp1[7][0], 5'b10101);
    chk("t5_src_clear", bp1[1][0], 5'd0);
    push_one(sq(0, 3), sq(0, 3), 5'd0);
    frame("t5_self");
    push_one(sq(0, 0), sq(2, 0), 5'd0);
    push_one(sq(6, 7), sq(5, 7), 5'd0);
    push_one(sq(1, 7), sq(2, 7), 5'd0);
    push_one(sq(7, 1), sq(5, 2), 5'd0);
    chk("t5_full_after4", rdy1, 0);
    frame("t6_moves");
    chk("t6_corner_clear", bp1[0][0], 5'd0);

    // init_req with moves queued: INIT wins and discards them
    push_one(sq(0, 4), sq(4, 4), 5'd0);
    push_one(sq(7, 4), sq(3, 4), 5'd0);
    init_req = 1'b1; m_init_pend = 1;
    tick();
    init_req = 1'b0;
    frame("t6_init");
    frame("t6_after_flush");

    // MAX_PER_FRAME=2 instance: three moves take two frames
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      src = sq(6, i); dst = sq(4, i); pro = 5'd0;
      chk("t4_ready", rdy2, 1);
      mv2 = 1'b1;
      tick();
      mv2 = 1'b0;
    end
    frame("t4_f1_dut1");
    chk("t4_f1_pulses", g_p2, 2);
    chk("t4_f1_busy", g_b2, 4);
    chk("t4_f1_a", bp2[4][1], 5'b00101);
    chk("t4_f1_third_pending", bp2[4][2], 5'd0);
    chk("t4_f1_third_src", bp2[6][2], 5'b00101);
    frame("t4_f2_dut1");
    chk("t4_f2_pulses", g_p2, 1);
    chk("t4_f2_busy", g_b2, 2);
    chk("t4_f2_dst", bp2[4][2], 5'b00101);
    chk("t4_f2_src", bp2[6][2], 5'd0);

    // Random traffic against the frame model
    for (int f = 0; f < 40; f++) begin
      k = $urandom_range(0, 5);
      for (int j = 0; j < k; j++) begin
        rs = 6'($urandom_range(0, 63));
        rd = ($urandom_range(0, 7) == 0) ? rs : 6'($urandom_range(0, 63));
        rp = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
        push_one(rs, rd, rp);
      end
      if ($urandom_range(0, 5) == 0) begin
        init_req = 1'b1; m_init_pend = 1;
        tick();
        init_req = 1'b0;
      end
      frame("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
